// File: rtl/dcache_store_buffer_pkg.sv
// Shared types and store-type encodings for the data-cache store buffer.
package dcache_store_buffer_pkg;

  localparam logic [1:0] SW = 2'b00;
  localparam logic [1:0] SH = 2'b01;
  localparam logic [1:0] SB = 2'b10;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  be;
  } sbuf_entry_t;

endpackage

// File: rtl/dcache_store_buffer_lane_align.sv
// Maps a right-aligned store (type, low address bits, data) onto word byte lanes.
module sbuf_lane_align
  import dcache_store_buffer_pkg::*;
(
  input  logic [1:0]  store_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  be,
  output logic [31:0] lane_data
);

  // Byte is the fallback so that the unused encoding 2'b11 behaves as SB.
  always_comb begin
    be        = 4'b0001 << addr_lo;
    lane_data = {4{st_data[7:0]}};
    case (store_type)
      SW: begin
        be        = 4'b1111;
        lane_data = st_data;
      end
      SH: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dcache_store_buffer.sv
// Posted-write store buffer feeding the data memory write port, with per-byte load forwarding.
module dcache_store_buffer
  import dcache_store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_StReq_i,
  input  logic        MEM_LdReq_i,
  input  logic [31:0] MEM_Addr_i,
  input  logic [31:0] MEM_StData_i,
  input  logic [1:0]  MEM_StoreType_i,
  output logic [31:0] MEM_LdData_o,
  output logic        MEM_Full_o,
  output logic        MEM_Empty_o,
  output logic [31:0] DM_Addr_o,
  output logic        DM_Wr_o,
  output logic [3:0]  DM_ByteEn_o,
  output logic [31:0] DM_WrData_o,
  input  logic [31:0] DM_RdData_i,
  input  logic        DM_Ready_i
);

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  sbuf_entry_t      entries [DEPTH];
  sbuf_entry_t      head_ent;
  logic [3:0]       new_be;
  logic [31:0]      new_data;
  logic             do_enq;
  logic [31:0]      fwd_data;

  sbuf_lane_align u_align (
    .store_type(MEM_StoreType_i),
    .addr_lo   (MEM_Addr_i[1:0]),
    .st_data   (MEM_StData_i),
    .be        (new_be),
    .lane_data (new_data)
  );

  assign head_ent    = entries[head];
  assign MEM_Full_o  = (count == (PTR_W+1)'(DEPTH));
  assign MEM_Empty_o = (count == '0);

  // Loads own the memory port; drains only use otherwise idle cycles.
  assign do_enq  = MEM_StReq_i & ~MEM_Full_o & ~rst;
  assign DM_Wr_o = ~MEM_Empty_o & ~MEM_LdReq_i & DM_Ready_i & ~rst;

  assign DM_Addr_o   = MEM_LdReq_i ? MEM_Addr_i :
                       (MEM_Empty_o ? 32'h0 : {head_ent.waddr, 2'b00});
  assign DM_ByteEn_o = MEM_Empty_o ? 4'b0000 : head_ent.be;
  assign DM_WrData_o = MEM_Empty_o ? 32'h0 : head_ent.data;

  // Control state: pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_enq)  tail <= tail + 1'b1;
      if (DM_Wr_o) head <= head + 1'b1;
      case ({do_enq, DM_Wr_o})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Entry storage carries no reset; validity comes from head/count.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      entries[tail] <= '{waddr: MEM_Addr_i[31:2], data: new_data, be: new_be};
    end
  end

  // Walk oldest to youngest so later matches overwrite earlier ones per lane.
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd_data = DM_RdData_i;
    idx      = head;
    for (int j = 0; j < DEPTH; j++) begin
      idx = head + PTR_W'(j);
      if (((PTR_W+1)'(j) < count) && (entries[idx].waddr == MEM_Addr_i[31:2])) begin
        for (int b = 0; b < 4; b++) begin
          if (entries[idx].be[b]) fwd_data[8*b +: 8] = entries[idx].data[8*b +: 8];
        end
      end
    end
  end

  assign MEM_LdData_o = rst ? DM_RdData_i : fwd_data;

endmodule
